aes_128_sbox_bank: RTL

- Multi-lane, runtime-selectable S-box / InvS-box lookup engine. It is the parametrised successor to the single-table dual-port S-box RAM.
- It serves LANES bytes per request through a valid/ready pipeline.
- Each request carries a per-request encrypt/decrypt mode.
- It has a table-rewrite port and a hardware restore-to-default sequencer.
- It sits between the round datapath (SubBytes/InvSubBytes) and an optional table-maintenance master.

---
 rtl/aes_128_sbox_pkg.sv | 59 +++++
 rtl/aes_128_sbox_lane.sv | 57 +++++
 rtl/aes_128_sbox_bank.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aes_128_sbox_pkg.sv
// Shared types and FIPS-197 default tables for the multi-lane S-box bank.
// sbox_default() is the single source of restore values for every lane.
package aes_128_sbox_pkg;

    typedef logic [7:0] sbox_t [256];

    typedef enum logic {
        SBOX_ENC = 1'b0,
        SBOX_DEC = 1'b1
    } sbox_mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } sbox_state_e;

    localparam sbox_t SBOX_FWD = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam sbox_t SBOX_INV = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_default(input logic tbl, input logic [7:0] addr);
        return (tbl == SBOX_DEC) ? SBOX_INV[addr] : SBOX_FWD[addr];
    endfunction

endpackage

// File: rtl/aes_128_sbox_lane.sv
// One substitution lane: private forward and inverse tables with a registered,
// mode-selected read port, a user write port and a default-restore write port.
module aes_128_sbox_lane
    import aes_128_sbox_pkg::*;
(
    input  logic       clk,
    input  logic       kill,
    input  logic       rd_en,
    input  logic       rd_mode,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       wr_en,
    input  logic       wr_tbl,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rs_en,
    input  logic [7:0] rs_addr
);

    // Tables power up holding the standard contents; kill never touches them.
    sbox_t fwd_mem = SBOX_FWD;
    sbox_t inv_mem = SBOX_INV;

    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (rs_en) begin
            fwd_mem[rs_addr] <= sbox_default(SBOX_ENC, rs_addr);
            inv_mem[rs_addr] <= sbox_default(SBOX_DEC, rs_addr);
        end else if (wr_en) begin
            if (wr_tbl == SBOX_DEC) begin
                inv_mem[wr_addr] <= wr_data;
            end else begin
                fwd_mem[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = (rd_mode == SBOX_DEC) ? inv_mem[rd_addr] : fwd_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/aes_128_sbox_bank.sv
// Multi-lane S-box / InvS-box lookup engine with valid/ready handshake,
// broadcast table rewrite and a 256-cycle restore-to-default sequencer.
module aes_128_sbox_bank
    import aes_128_sbox_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int TAG_W    = 4,
    parameter int PIPE_OUT = 0
) (
    input  logic                 clk,
    input  logic                 kill,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [LANES*8-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*8-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    input  logic                 wr_en,
    output logic                 wr_ready,
    input  logic                 wr_tbl,
    input  logic [7:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 restore,
    output logic                 busy
);

    sbox_state_e        state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               idle;
    logic               adv;
    logic               wr_acc;
    logic               rd_acc;
    logic               rs_en;
    logic [LANES*8-1:0] lane_data;
    logic               vld_p1_q, vld_p1_d;
    logic [TAG_W-1:0]   tag_p1_q, tag_p1_d;

    assign idle     = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_RESTORE);
    assign wr_ready = idle && !restore;
    assign wr_acc   = wr_en && wr_ready;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && idle && !restore && !wr_acc;
    assign rd_acc   = in_valid && in_ready;
    // The entry under the counter is not written on the cycle kill aborts the sweep.
    assign rs_en    = busy && !kill;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (restore) begin
                    state_d = ST_RESTORE;
                    cnt_d   = '0;
                end
            end
            ST_RESTORE: begin
                if (cnt_q == 8'hff) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_128_sbox_lane u_lane (
            .clk     (clk),
            .kill    (kill),
            .rd_en   (rd_acc),
            .rd_mode (in_mode),
            .rd_addr (in_data[8*i +: 8]),
            .rd_data (lane_data[8*i +: 8]),
            .wr_en   (wr_acc),
            .wr_tbl  (wr_tbl),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rs_en   (rs_en),
            .rs_addr (cnt_q)
        );
    end

    // ---- stage p1: table read result (inside the lanes), tag and valid ----
    always_comb begin
        vld_p1_d = vld_p1_q;
        tag_p1_d = tag_p1_q;
        if (adv) begin
            vld_p1_d = rd_acc;
            if (rd_acc) begin
                tag_p1_d = in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            vld_p1_q <= 1'b0;
            tag_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            tag_p1_q <= tag_p1_d;
        end
    end

    // ---- stage p2: optional output register, stalled with the whole pipe ----
    if (PIPE_OUT != 0) begin : g_pipe_out
        logic               vld_p2_q;
        logic [LANES*8-1:0] data_p2_q;
        logic [TAG_W-1:0]   tag_p2_q;

        always_ff @(posedge clk) begin
            if (kill) begin
                vld_p2_q  <= 1'b0;
                data_p2_q <= '0;
                tag_p2_q  <= '0;
            end else if (adv) begin
                vld_p2_q  <= vld_p1_q;
                data_p2_q <= lane_data;
                tag_p2_q  <= tag_p1_q;
            end
        end

        assign out_valid = vld_p2_q;
        assign out_data  = data_p2_q;
        assign out_tag   = tag_p2_q;
    end else begin : g_direct_out
        assign out_valid = vld_p1_q;
        assign out_data  = lane_data;
        assign out_tag   = tag_p1_q;
    end

endmodule
